// File: rtl/board_init_axi_lite_slave_if.sv
// AXI4-Lite control-bus bundle for the BoardInit register block.
// The master modport is the bus driver (PS or BFM); the slave modport is the register block.
interface board_init_axi_lite_slave_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   S_AXI_AWADDR;
   logic [2:0]          S_AXI_AWPROT;
   logic                S_AXI_AWVALID;
   logic                S_AXI_AWREADY;
   logic [DATA_W-1:0]   S_AXI_WDATA;
   logic [DATA_W/8-1:0] S_AXI_WSTRB;
   logic                S_AXI_WVALID;
   logic                S_AXI_WREADY;
   logic [1:0]          S_AXI_BRESP;
   logic                S_AXI_BVALID;
   logic                S_AXI_BREADY;
   logic [ADDR_W-1:0]   S_AXI_ARADDR;
   logic [2:0]          S_AXI_ARPROT;
   logic                S_AXI_ARVALID;
   logic                S_AXI_ARREADY;
   logic [DATA_W-1:0]   S_AXI_RDATA;
   logic [1:0]          S_AXI_RRESP;
   logic                S_AXI_RVALID;
   logic                S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/board_init_axi_lite_slave.sv
// AXI4-Lite responder holding four 32-bit BoardInit config registers,
// with byte-strobed writes, registered reads and per-register write pulses.
module board_init_axi_lite_slave #(
   parameter int                               C_S_AXI_DATA_WIDTH = 32,
   parameter int                               C_S_AXI_ADDR_WIDTH = 4,
   parameter logic [4*C_S_AXI_DATA_WIDTH-1:0]  C_RESET_VALUES     = '0
)(
   input  logic                               S_AXI_ACLK,
   input  logic                               S_AXI_ARESETN,
   board_init_axi_lite_slave_if.slave         s_axi,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0]    cfg_regs,
   output logic [3:0]                         cfg_wr_pulse
);
   localparam int DW = C_S_AXI_DATA_WIDTH;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA} rstate_t;

   wstate_t              r_wstate, w_wnext;
   rstate_t              r_rstate, w_rnext;
   logic [1:0]           r_awidx;
   logic [DW-1:0]        r_wdata;
   logic [3:0]           r_wstrb;
   logic [3:0][DW-1:0]   r_regs;
   logic [DW-1:0]        r_rdata;
   logic [3:0]           r_pulse;

   logic                 w_commit;
   logic [1:0]           w_cidx;
   logic [DW-1:0]        w_cdata;
   logic [3:0]           w_cstrb;
   logic                 w_aw_hs, w_w_hs, w_ar_hs;
   logic                 w_unused;

   wire [1:0] w_awidx_in = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   wire [1:0] w_aridx_in = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

   assign s_axi.S_AXI_AWREADY = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_W);
   assign s_axi.S_AXI_WREADY  = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_AW);
   assign s_axi.S_AXI_BVALID  = (r_wstate == W_RESP);
   assign s_axi.S_AXI_BRESP   = 2'b00;
   assign s_axi.S_AXI_ARREADY = (r_rstate == R_IDLE);
   assign s_axi.S_AXI_RVALID  = (r_rstate == R_DATA);
   assign s_axi.S_AXI_RRESP   = 2'b00;
   assign s_axi.S_AXI_RDATA   = r_rdata;
   assign cfg_regs            = r_regs;
   assign cfg_wr_pulse        = r_pulse;

   assign w_aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
   assign w_w_hs  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
   assign w_ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
   assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

   // Commit takes whichever half arrived this cycle straight from the bus,
   // and the other half from the holding registers.
   always_comb begin
      w_wnext  = r_wstate;
      w_commit = 1'b0;
      w_cidx   = w_awidx_in;
      w_cdata  = s_axi.S_AXI_WDATA;
      w_cstrb  = s_axi.S_AXI_WSTRB;
      unique case (r_wstate)
         W_IDLE: begin
            if (w_aw_hs && w_w_hs) begin
               w_commit = 1'b1;
               w_wnext  = W_RESP;
            end else if (w_aw_hs) begin
               w_wnext  = W_HAVE_AW;
            end else if (w_w_hs) begin
               w_wnext  = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            w_cidx = r_awidx;
            if (w_w_hs) begin
               w_commit = 1'b1;
               w_wnext  = W_RESP;
            end
         end
         W_HAVE_W: begin
            w_cdata = r_wdata;
            w_cstrb = r_wstrb;
            if (w_aw_hs) begin
               w_commit = 1'b1;
               w_wnext  = W_RESP;
            end
         end
         W_RESP: if (s_axi.S_AXI_BREADY) w_wnext = W_IDLE;
         default: w_wnext = W_IDLE;
      endcase
   end

   always_comb begin
      w_rnext = r_rstate;
      unique case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
         R_DATA:  if (s_axi.S_AXI_RREADY) w_rnext = R_IDLE;
         default: w_rnext = R_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_wstate <= W_IDLE;
         r_rstate <= R_IDLE;
         r_awidx  <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_regs   <= C_RESET_VALUES;
         r_rdata  <= '0;
         r_pulse  <= '0;
      end else begin
         r_wstate <= w_wnext;
         r_rstate <= w_rnext;
         r_pulse  <= '0;
         if (r_wstate == W_IDLE && w_aw_hs) r_awidx <= w_awidx_in;
         if (r_wstate == W_IDLE && w_w_hs) begin
            r_wdata <= s_axi.S_AXI_WDATA;
            r_wstrb <= s_axi.S_AXI_WSTRB;
         end
         if (w_commit) begin
            r_pulse[w_cidx] <= 1'b1;
            for (int b = 0; b < 4; b++)
               if (w_cstrb[b]) r_regs[w_cidx][8*b +: 8] <= w_cdata[8*b +: 8];
         end
         // Register array is sampled before this edge's commit lands,
         // so a colliding read sees the pre-write value.
         if (w_ar_hs) r_rdata <= r_regs[w_aridx_in];
      end
   end
endmodule

// File: doc/board_init_axi_lite_slave.md
# board_init_axi_lite_slave

AXI4-Lite responder exposing four 32-bit read/write configuration registers for the BoardInit peripheral. It terminates the control bus driven by the PS or a master BFM: it accepts write address/data and read address independently, returns OKAY responses, and presents register contents plus per-register write pulses to downstream board-initialisation logic.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register and bits [1:0] are ignored.
- C_RESET_VALUES, 128'h0, packed reset values; reg n = bits [32n+31:32n].
- S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
- S_AXI_ARESETN  in  1  synchronous, active-low reset.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; bit b gates WDATA[8b+7:8b].
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- cfg_regs  out  128  current register contents, packed as for C_RESET_VALUES.
- cfg_wr_pulse  out  4  one-cycle pulse on bit n in the cycle after register n is written.

## Operation
- Write FSM states:
  - W_IDLE: AWREADY=1, WREADY=1.
  - W_HAVE_AW: AWREADY=0, WREADY=1.
  - W_HAVE_W: AWREADY=1, WREADY=0.
  - W_RESP: both 0, BVALID=1.
- Write transitions:
  - W_IDLE, AW and W both handshake in the same cycle -> commit, go to W_RESP.
  - W_IDLE, AW only -> latch address, go to W_HAVE_AW.
  - W_IDLE, W only -> latch data and strobe, go to W_HAVE_W.
  - W_HAVE_AW plus W handshake, or W_HAVE_W plus AW handshake -> commit, go to W_RESP.
  - W_RESP plus BREADY -> W_IDLE.
- Commit: reg[addr[3:2]] byte b is updated only where WSTRB[b]=1. WSTRB=0 commits nothing, but BVALID is still returned and cfg_wr_pulse still fires.
- Read FSM states:
  - R_IDLE: ARREADY=1.
  - R_DATA: ARREADY=0, RVALID=1.
- Read transitions:
  - R_IDLE, AR handshake -> capture reg[ARADDR[3:2]] into RDATA, go to R_DATA.
  - R_DATA plus RREADY -> R_IDLE.
- RDATA is held stable while RVALID=1 and RREADY=0.
- Read and write channels are fully independent; each allows one outstanding transaction.
- Read and write to the same register committing in the same cycle: RDATA returns the pre-write value.
- VALID/READY rules:
  - Slave never waits on RREADY/BREADY before asserting RVALID/BVALID.
  - Once RVALID/BVALID is asserted, it holds until its handshake.

## Timing
- Reset (S_AXI_ARESETN=0 at a clock edge) forces:
  - both FSMs to IDLE, so AWREADY=WREADY=ARREADY=1 from the first cycle after reset;
  - BVALID=RVALID=0, RDATA=0, BRESP=RRESP=0, cfg_wr_pulse=0;
  - cfg_regs=C_RESET_VALUES.
- Reset mid-transaction abandons it: no commit, no response, latched address and data are discarded.
- Write latency: the completing handshake in cycle N updates cfg_regs and drives BVALID=1 and cfg_wr_pulse in cycle N+1.
- Write throughput: with BREADY tied high, one write per 2 cycles.
- Read latency: AR handshake in cycle N gives RVALID=1 with RDATA in cycle N+1.
- Read throughput: with RREADY tied high, one read per 2 cycles.
- All outputs are registered or decoded directly from registered state; no combinational path from any input to any output.

## Test plan
- Concurrent AW+W, then read, for each test vector -> BRESP=0, RRESP=0, readback matches exactly:
  - 0x0101FFFF to addr 0x0;
  - 0xabcd0001 to addr 0x4;
  - 0xdead0011 to addr 0x8;
  - 0xbeef0011 to addr 0xC.
- Reset release -> cfg_regs=C_RESET_VALUES, all READYs=1, VALIDs=0. Then write reg2 with WSTRB=4'b0101, WDATA=0x11223344 over 0xdead0011 -> reg2=0xde220044, cfg_wr_pulse=4'b0100 for exactly one cycle.
- AW at addr 0x4 presented 3 cycles before W=0x12345678 -> WREADY stays 1 and AWREADY=0 while waiting. BVALID rises the cycle after the W handshake; reg1=0x12345678. Repeat with W first.
- BREADY held low 5 cycles, and separately RREADY held low 5 cycles -> BVALID/RVALID and RDATA stay stable. AWREADY=WREADY=0 until the B handshake.
- Same-cycle write 0xCAFEF00D to addr 0x8 and AR at addr 0x8 -> RDATA is the old value; a following read returns 0xCAFEF00D.
- S_AXI_ARESETN=0 for 1 cycle between AW and W handshakes -> no register change, no BVALID. The next full write behaves normally.
